cache_controller: RTL

Request-side controller for the 4-way set-associative `cache_memory`. It accepts single-word CPU loads and stores, runs the tag lookup in the cache, and fills read misses from backing memory. It selects the victim way with a per-set round-robin pointer that drives the cache's `replace_way` input. The write policy is write-through / write-allocate. The block sits between the CPU port and `cache_memory` plus main memory.

---
 rtl/cache_controller.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/cache_controller.sv
// cache_controller: CPU-side request FSM for a set-associative write-through,
// write-allocate cache. Runs the lookup, fills read misses from memory,
// forwards stores to memory and picks victims with per-set round-robin pointers.
module cache_controller #(
    parameter int NUM_SETS = 32,
    parameter int NUM_WAYS = 4,
    parameter int CNT_W    = 16
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        cpu_req,
    input  logic                        cpu_we,
    input  logic [31:0]                 cpu_addr,
    input  logic [31:0]                 cpu_wdata,
    output logic [31:0]                 cpu_rdata,
    output logic                        cpu_ready,
    output logic                        cache_read,
    output logic                        cache_write,
    output logic [31:0]                 cache_addr,
    output logic [31:0]                 cache_wdata,
    output logic [$clog2(NUM_WAYS)-1:0] replace_way,
    input  logic [31:0]                 cache_rdata,
    input  logic                        cache_hit,
    output logic                        mem_req,
    output logic                        mem_we,
    output logic [31:0]                 mem_addr,
    output logic [31:0]                 mem_wdata,
    input  logic [31:0]                 mem_rdata,
    input  logic                        mem_ack,
    output logic [CNT_W-1:0]            hit_cnt,
    output logic [CNT_W-1:0]            miss_cnt
);
    localparam int IDX_W = $clog2(NUM_SETS);
    localparam int WAY_W = $clog2(NUM_WAYS);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [WAY_W-1:0] WAY_LAST = WAY_W'(NUM_WAYS - 1);

    typedef enum logic [2:0] {
        IDLE, LOOKUP, MEM_RD, FILL, CWRITE, MEM_WR, RESP
    } state_t;

    state_t                           state_q, state_d;
    logic [31:0]                      addr_q, addr_d;
    logic                             we_q, we_d;
    logic [31:0]                      wdata_q, wdata_d;
    logic                             hit_q, hit_d;
    logic [31:0]                      fill_q, fill_d;
    logic [31:0]                      rdata_q, rdata_d;
    logic [CNT_W-1:0]                 hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0]                 miss_cnt_q, miss_cnt_d;
    logic [NUM_SETS-1:0][WAY_W-1:0]   ptr_q, ptr_d;

    logic [IDX_W-1:0] idx;
    logic [WAY_W-1:0] ptr_cur, ptr_nxt;

    assign idx     = addr_q[IDX_W+1:2];
    assign ptr_cur = ptr_q[idx];
    assign ptr_nxt = (ptr_cur == WAY_LAST) ? '0 : ptr_cur + WAY_W'(1);

    // Next-state logic: transaction sequencing, data capture, counters, victim pointers
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        hit_d      = hit_q;
        fill_d     = fill_q;
        rdata_d    = rdata_q;
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        ptr_d      = ptr_q;
        case (state_q)
            IDLE: begin
                if (cpu_req) begin
                    addr_d  = cpu_addr;
                    we_d    = cpu_we;
                    wdata_d = cpu_wdata;
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                if (cache_hit) begin
                    if (hit_cnt_q != CNT_MAX) hit_cnt_d = hit_cnt_q + 1'b1;
                end else begin
                    if (miss_cnt_q != CNT_MAX) miss_cnt_d = miss_cnt_q + 1'b1;
                end
                if (we_q) begin
                    hit_d   = cache_hit;
                    state_d = CWRITE;
                end else if (cache_hit) begin
                    rdata_d = cache_rdata;
                    state_d = RESP;
                end else begin
                    state_d = MEM_RD;
                end
            end
            MEM_RD: begin
                if (mem_ack) begin
                    fill_d  = mem_rdata;
                    rdata_d = mem_rdata;
                    state_d = FILL;
                end
            end
            FILL: begin
                ptr_d[idx] = ptr_nxt;
                state_d    = RESP;
            end
            CWRITE: begin
                // A store hit rewrites the resident line, so the victim pointer stays put
                if (!hit_q) ptr_d[idx] = ptr_nxt;
                state_d = MEM_WR;
            end
            MEM_WR: begin
                if (mem_ack) state_d = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State registers; async reset aborts any in-flight transaction
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            hit_q      <= 1'b0;
            fill_q     <= '0;
            rdata_q    <= '0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
            ptr_q      <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            hit_q      <= hit_d;
            fill_q     <= fill_d;
            rdata_q    <= rdata_d;
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
            ptr_q      <= ptr_d;
        end
    end

    // Output decode: strobes are pure functions of state so reset drops them at once
    always_comb begin
        cpu_ready   = (state_q == RESP);
        cache_read  = (state_q == LOOKUP);
        cache_write = (state_q == FILL) || (state_q == CWRITE);
        mem_req     = (state_q == MEM_RD) || (state_q == MEM_WR);
        mem_we      = (state_q == MEM_WR);
        cache_addr  = addr_q;
        mem_addr    = addr_q;
        cache_wdata = '0;
        if (state_q == FILL)        cache_wdata = fill_q;
        else if (state_q == CWRITE) cache_wdata = wdata_q;
        replace_way = cache_write ? ptr_cur : '0;
        mem_wdata   = mem_we ? wdata_q : '0;
        cpu_rdata   = rdata_q;
        hit_cnt     = hit_cnt_q;
        miss_cnt    = miss_cnt_q;
    end

endmodule
